// File: rtl/mod12_pkg.sv
// Shared definitions for the mod-12 counter and its receive-side sequence checker.
package mod12_pkg;

    localparam int unsigned MOD12 = 12;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_e;

    // Successor of x in a modulo-m sequence.
    function automatic int unsigned next_count(input int unsigned x, input int unsigned m);
        return (x == m - 1) ? 0 : x + 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter with synchronous clear (clear wins over increment) and optional saturation.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic         sat,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !(sat && (&count_q))) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mod12_seq_checker.sv
// Tracks the expected next value of a mod-MOD count stream; reports lock, error pulses and
// error/wrap statistics.
module mod12_seq_checker
    import mod12_pkg::*;
#(
    parameter int unsigned MOD      = MOD12,
    parameter int unsigned W        = CNT_W,
    parameter int unsigned LOCK_CNT = 2,
    parameter int unsigned STAT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [W-1:0]      cnt_in,
    input  logic              load_seen,
    input  logic              clr_stats,
    output logic              locked,
    output logic              err_pulse,
    output logic [STAT_W-1:0] err_count,
    output logic [STAT_W-1:0] wrap_count,
    output logic [W-1:0]      expected
);

    localparam int unsigned MW = $clog2(LOCK_CNT + 1);

    state_e        state_q, state_d;
    logic [W-1:0]  exp_q, exp_d;
    logic [MW-1:0] match_q, match_d;
    logic          err_pulse_q;
    logic [W-1:0]  cnt_next;
    logic          range_err;
    logic          err;
    logic          wrap;

    always_comb begin
        cnt_next  = W'(next_count(32'(cnt_in), MOD));
        range_err = (32'(cnt_in) >= MOD);
        state_d   = state_q;
        exp_d     = exp_q;
        match_d   = match_q;
        err       = 1'b0;
        wrap      = 1'b0;
        if (en) begin
            if (range_err) begin
                err     = 1'b1;
                state_d = HUNT;
                match_d = '0;
            end else begin
                unique case (state_q)
                    HUNT: begin
                        exp_d   = cnt_next;
                        match_d = '0;
                        state_d = SYNC;
                    end
                    SYNC: begin
                        // A mismatch here just reseeds; load_seen is irrelevant.
                        exp_d = cnt_next;
                        if (cnt_in == exp_q) begin
                            if (32'(match_q) + 1 >= LOCK_CNT) begin
                                match_d = '0;
                                state_d = LOCKED;
                            end else begin
                                match_d = match_q + 1'b1;
                            end
                        end else begin
                            match_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (cnt_in == exp_q) begin
                            exp_d = cnt_next;
                            // Expected 0 while locked only arises from a prior MOD-1.
                            wrap  = (cnt_in == '0);
                        end else if (load_seen) begin
                            exp_d = cnt_next;
                        end else begin
                            err     = 1'b1;
                            state_d = HUNT;
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            exp_q       <= '0;
            match_q     <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            match_q     <= match_d;
            err_pulse_q <= err;
        end
    end

    sat_counter #(.W(STAT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_stats),
        .inc   (err),
        .sat   (1'b1),
        .count (err_count)
    );

    sat_counter #(.W(STAT_W)) u_wrap_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_stats),
        .inc   (wrap),
        .sat   (1'b0),
        .count (wrap_count)
    );

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign expected  = exp_q;

endmodule

// File: tb/tb_mod12_seq_checker.sv
// Directed self-checking bench for mod12_seq_checker with hand-computed expectations.
module tb_mod12_seq_checker;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] cnt_in;
    logic       load_seen;
    logic       clr_stats;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [7:0] wrap_count;
    logic [3:0] expected;

    int errors = 0;
    int checks = 0;

    mod12_seq_checker dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cnt_in     (cnt_in),
        .load_seen  (load_seen),
        .clr_stats  (clr_stats),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .wrap_count (wrap_count),
        .expected   (expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Drive one sample, clock it in, and settle past the edge before checking.
    task automatic step(input logic e, input logic [3:0] c, input logic l);
        en        = e;
        cnt_in    = c;
        load_seen = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        cnt_in    = '0;
        load_seen = 1'b0;
        clr_stats = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err_pulse", 32'(err_pulse), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_wrap_count", 32'(wrap_count), 0);
        chk("rst_expected", 32'(expected), 0);
        rst = 1'b0;

        // Free run 0..11: seed + 2 matches locks on the third sample.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 4'(i), 1'b0);
            chk("run_err_count", 32'(err_count), 0);
            if (i == 1) chk("run_not_locked_yet", 32'(locked), 0);
            if (i == 2) chk("run_locked", 32'(locked), 1);
        end
        chk("run_expected_after_11", 32'(expected), 0);
        step(1'b1, 4'd0, 1'b0);
        chk("run_wrap", 32'(wrap_count), 1);
        chk("run_expected_after_0", 32'(expected), 1);
        step(1'b1, 4'd1, 1'b0);
        chk("run_err_count_end", 32'(err_count), 0);

        // Locked at 5, inject 7 without load.
        for (int i = 2; i <= 5; i++) step(1'b1, 4'(i), 1'b0);
        chk("pre_inject_expected", 32'(expected), 6);
        step(1'b1, 4'd7, 1'b0);
        chk("inject_err_pulse", 32'(err_pulse), 1);
        chk("inject_err_count", 32'(err_count), 1);
        chk("inject_unlocked", 32'(locked), 0);
        step(1'b1, 4'd8, 1'b0);
        chk("inject_pulse_one_cycle", 32'(err_pulse), 0);
        chk("reseed_expected", 32'(expected), 9);
        step(1'b1, 4'd9, 1'b0);
        chk("relock_not_yet", 32'(locked), 0);
        step(1'b1, 4'd10, 1'b0);
        chk("relock", 32'(locked), 1);

        // Legal reload 5 -> 9 while locked, then wrap.
        step(1'b1, 4'd11, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        chk("wrap_two", 32'(wrap_count), 2);
        for (int i = 1; i <= 5; i++) step(1'b1, 4'(i), 1'b0);
        step(1'b1, 4'd9, 1'b1);
        chk("reload_locked", 32'(locked), 1);
        chk("reload_no_pulse", 32'(err_pulse), 0);
        chk("reload_expected", 32'(expected), 10);
        step(1'b1, 4'd10, 1'b0);
        step(1'b1, 4'd11, 1'b0);
        step(1'b1, 4'd0, 1'b0);
        chk("reload_wrap", 32'(wrap_count), 3);
        chk("reload_err_count", 32'(err_count), 1);
        chk("reload_still_locked", 32'(locked), 1);

        // Out-of-range in LOCKED, HUNT, then SYNC.
        step(1'b1, 4'd13, 1'b0);
        chk("range_locked_pulse", 32'(err_pulse), 1);
        chk("range_locked_count", 32'(err_count), 2);
        chk("range_locked_unlock", 32'(locked), 0);
        step(1'b1, 4'd13, 1'b0);
        chk("range_hunt_pulse", 32'(err_pulse), 1);
        chk("range_hunt_count", 32'(err_count), 3);
        step(1'b1, 4'd4, 1'b0);
        chk("range_seed_no_pulse", 32'(err_pulse), 0);
        step(1'b1, 4'd13, 1'b1);
        chk("range_sync_pulse", 32'(err_pulse), 1);
        chk("range_sync_count", 32'(err_count), 4);
        // Back in HUNT: 5 only seeds, 6 is the first match, so still unlocked.
        step(1'b1, 4'd5, 1'b0);
        step(1'b1, 4'd6, 1'b0);
        chk("range_sync_to_hunt", 32'(locked), 0);
        step(1'b1, 4'd7, 1'b0);
        chk("range_relock", 32'(locked), 1);

        // Saturation: 259 more errors from a count of 4.
        for (int i = 0; i < 259; i++) step(1'b1, 4'd15, 1'b0);
        chk("sat_err_count", 32'(err_count), 255);
        chk("sat_err_pulse", 32'(err_pulse), 1);
        chk("sat_wrap_unchanged", 32'(wrap_count), 3);

        // en=0 mid-lock with garbage on cnt_in.
        step(1'b1, 4'd0, 1'b0);
        step(1'b1, 4'd1, 1'b0);
        step(1'b1, 4'd2, 1'b0);
        chk("hold_pre_locked", 32'(locked), 1);
        step(1'b0, 4'd13, 1'b0);
        chk("hold_expected_0", 32'(expected), 3);
        chk("hold_pulse_0", 32'(err_pulse), 0);
        step(1'b0, 4'd7, 1'b1);
        chk("hold_expected_1", 32'(expected), 3);
        step(1'b0, 4'd15, 1'b0);
        chk("hold_pulse_2", 32'(err_pulse), 0);
        step(1'b0, 4'd9, 1'b0);
        chk("hold_expected_3", 32'(expected), 3);
        chk("hold_locked", 32'(locked), 1);
        chk("hold_err_count", 32'(err_count), 255);
        step(1'b1, 4'd3, 1'b0);
        chk("resume_locked", 32'(locked), 1);
        chk("resume_expected", 32'(expected), 4);
        chk("resume_no_pulse", 32'(err_pulse), 0);

        // clr_stats coincident with a mismatch error: clear wins, pulse still fires.
        clr_stats = 1'b1;
        step(1'b1, 4'd9, 1'b0);
        clr_stats = 1'b0;
        chk("clr_err_pulse", 32'(err_pulse), 1);
        chk("clr_err_count", 32'(err_count), 0);
        chk("clr_wrap_count", 32'(wrap_count), 0);
        chk("clr_unlocked", 32'(locked), 0);

        // Build nonzero state, then reset mid-lock.
        step(1'b1, 4'd9, 1'b0);
        step(1'b1, 4'd10, 1'b0);
        step(1'b1, 4'd11, 1'b0);
        chk("pre_rst_locked", 32'(locked), 1);
        step(1'b1, 4'd0, 1'b0);
        chk("pre_rst_wrap", 32'(wrap_count), 1);
        step(1'b1, 4'd5, 1'b0);
        chk("pre_rst_err_count", 32'(err_count), 1);
        step(1'b1, 4'd6, 1'b0);
        step(1'b1, 4'd7, 1'b0);
        step(1'b1, 4'd8, 1'b0);
        chk("pre_rst_relock", 32'(locked), 1);
        rst = 1'b1;
        step(1'b1, 4'd9, 1'b0);
        chk("mid_rst_locked", 32'(locked), 0);
        chk("mid_rst_err_pulse", 32'(err_pulse), 0);
        chk("mid_rst_err_count", 32'(err_count), 0);
        chk("mid_rst_wrap_count", 32'(wrap_count), 0);
        chk("mid_rst_expected", 32'(expected), 0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
